uart_program_loader: RTL

- Upstream of the core. Receives a program over a UART serial line and writes it word by word into instruction memory, starting at address 0.
- When the whole program has been written, it raises load_done. load_done releases the core's FETCH state machine.
- Wire format: 4-byte word count N, then N 32-bit instruction words. All multi-byte fields are big-endian.

---
 rtl/uart_program_loader.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// UART program loader: receives a big-endian word count followed by that many
// 32-bit words over 8N1 serial and writes them into instruction memory from address 0.
module uart_program_loader #(
  parameter int CLK_PER_BIT = 868,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [32:0]      MAX_N     = 33'd1 << ADDR_W;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] LD_HDR  = 2'd0;
  localparam logic [1:0] LD_DATA = 2'd1;
  localparam logic [1:0] LD_DONE = 2'd2;
  localparam logic [1:0] LD_ERR  = 2'd3;

  logic              sync_meta_r;
  logic              rxs_r;
  logic [1:0]        rx_state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic [7:0]        rx_byte_r;
  logic              byte_valid_r;
  logic              frame_err_r;

  logic [1:0]        ld_state_r;
  logic [1:0]        byte_idx_r;
  logic [31:0]       n_r;
  logic [31:0]       idx_r;
  logic [31:0]       asm_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic              busy_r;
  logic              load_done_r;
  logic              err_r;

  logic [31:0]       hdr_next_s;
  logic [31:0]       word_next_s;

  assign hdr_next_s  = {n_r[23:0], rx_byte_r};
  assign word_next_s = {asm_r[23:0], rx_byte_r};

  assign we        = we_r;
  assign waddr     = waddr_r;
  assign wdata     = wdata_r;
  assign busy      = busy_r;
  assign load_done = load_done_r;
  assign err       = err_r;

  // Two-flop synchroniser for the asynchronous receive line
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_meta_r <= 1'b1;
      rxs_r       <= 1'b1;
    end else begin
      sync_meta_r <= rxd;
      rxs_r       <= sync_meta_r;
    end
  end

  // Byte receiver: mid-bit sampling, LSB first, stop bit checked for framing
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state_r   <= RX_IDLE;
      cnt_r        <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      rx_byte_r    <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          cnt_r <= CNT_ZERO;
          if (!rxs_r) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            rx_state_r <= rxs_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {rxs_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r      <= CNT_ZERO;
            rx_state_r <= RX_IDLE;
            if (rxs_r) begin
              rx_byte_r    <= shift_r;
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          cnt_r      <= CNT_ZERO;
        end
      endcase
    end
  end

  // Loader: header collection, word assembly, memory writes and sticky status
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_state_r  <= LD_HDR;
      byte_idx_r  <= 2'd0;
      n_r         <= 32'd0;
      idx_r       <= 32'd0;
      asm_r       <= 32'd0;
      we_r        <= 1'b0;
      waddr_r     <= {ADDR_W{1'b0}};
      wdata_r     <= 32'd0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      we_r <= 1'b0;
      case (ld_state_r)
        LD_HDR: begin
          if (frame_err_r) begin
            ld_state_r <= LD_ERR;
          end else if (byte_valid_r) begin
            busy_r     <= 1'b1;
            n_r        <= hdr_next_s;
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              idx_r <= 32'd0;
              // Compare in 33 bits so a full 32-bit count cannot alias the limit
              if ({1'b0, hdr_next_s} > MAX_N) begin
                ld_state_r <= LD_ERR;
              end else if (hdr_next_s == 32'd0) begin
                ld_state_r <= LD_DONE;
              end else begin
                ld_state_r <= LD_DATA;
              end
            end
          end
        end
        LD_DATA: begin
          if (frame_err_r) begin
            ld_state_r <= LD_ERR;
          end else if (byte_valid_r) begin
            asm_r      <= word_next_s;
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              we_r    <= 1'b1;
              wdata_r <= word_next_s;
              waddr_r <= idx_r[ADDR_W-1:0];
              idx_r   <= idx_r + 32'd1;
              if (idx_r == n_r - 32'd1) begin
                ld_state_r <= LD_DONE;
              end
            end
          end
        end
        LD_DONE: begin
          load_done_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        LD_ERR: begin
          err_r  <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          ld_state_r <= LD_ERR;
        end
      endcase
    end
  end

endmodule
